// File: rtl/dot_prod_feeder.sv
// Streams signed element pairs into the engine's two arrays (top-down from DEPTH-1),
// kicks the engine, waits for its done flag and holds the result for a downstream consumer.
module dot_prod_feeder #(
    parameter int DEPTH  = 1000,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 27,
    parameter int ACC_W  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    // element-pair stream
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    // engine control
    output logic              r_enable,
    output logic [ADDR_W-1:0] init_i_t_a,
    output logic [ACC_W-1:0]  init_acc_t_a,
    output logic              controlArr,
    output logic              controlArrWEnable_a,
    output logic              controlArrWEnable_b,
    output logic [ADDR_W-1:0] controlArrAddr_a,
    output logic [ADDR_W-1:0] controlArrAddr_b,
    output logic [DATA_W-1:0] controlArrWData_a,
    output logic [DATA_W-1:0] controlArrWData_b,
    input  logic              w_enable,
    input  logic [ACC_W-1:0]  result,
    // result stream
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_result,
    output logic [10:0]       out_count,
    output logic [15:0]       out_cycles
);

    typedef enum logic [1:0] {LOAD, KICK, RUN, HOLD} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] init_q, init_d;
    logic [10:0]       count_q, count_d;
    logic [15:0]       cycles_q, cycles_d;
    logic [ACC_W-1:0]  result_q, result_d;

    logic              accept;
    logic              job_end;
    logic [ADDR_W-1:0] wr_addr;

    // in_ready is gated by rst_n so nothing is accepted while reset is held
    assign in_ready = (state_q == LOAD) & rst_n;
    assign accept   = in_valid & in_ready;
    assign wr_addr  = LAST_ADDR - idx_q;
    assign job_end  = accept & (in_last | (idx_q == LAST_ADDR));

    assign controlArrWEnable_a = accept;
    assign controlArrWEnable_b = accept;
    assign controlArrAddr_a    = wr_addr;
    assign controlArrAddr_b    = wr_addr;
    assign controlArrWData_a   = in_a;
    assign controlArrWData_b   = in_b;

    assign init_i_t_a   = init_q;
    assign init_acc_t_a = '0;
    assign out_result   = result_q;
    assign out_count    = count_q;
    assign out_cycles   = cycles_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= LOAD;
            idx_q    <= '0;
            init_q   <= LAST_ADDR;
            count_q  <= '0;
            cycles_q <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            init_q   <= init_d;
            count_q  <= count_d;
            cycles_q <= cycles_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        init_d     = init_q;
        count_d    = count_q;
        cycles_d   = cycles_q;
        result_d   = result_q;
        r_enable   = 1'b1;
        controlArr = 1'b0;
        out_valid  = 1'b0;

        unique case (state_q)
            LOAD: begin
                controlArr = 1'b1;
                if (job_end) begin
                    // lowest written address is the engine's start index (DEPTH-N)
                    state_d = KICK;
                    count_d = 11'(idx_q) + 11'd1;
                    init_d  = wr_addr;
                end else if (accept) begin
                    idx_d = idx_q + 1'b1;
                end
            end
            KICK: begin
                state_d = RUN;
            end
            RUN: begin
                r_enable = 1'b0;
                if (cycles_q != 16'hFFFF) cycles_d = cycles_q + 16'd1;
                if (w_enable) begin
                    result_d = result;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d  = LOAD;
                    cycles_d = '0;
                    idx_d    = '0;
                end
            end
            default: state_d = LOAD;
        endcase
    end

endmodule

// File: tb/tb_dot_prod_feeder.sv
// Directed bench for dot_prod_feeder with a behavioural engine model behind the array ports.
module tb_dot_prod_feeder;
    localparam int DEPTH  = 1000;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 27;
    localparam int ACC_W  = 64;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid, in_ready, in_last;
    logic [DATA_W-1:0] in_a, in_b;
    logic              r_enable, controlArr;
    logic [ADDR_W-1:0] init_i_t_a;
    logic [ACC_W-1:0]  init_acc_t_a;
    logic              we_a, we_b;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic [DATA_W-1:0] wd_a, wd_b;
    logic              w_enable;
    logic [ACC_W-1:0]  result;
    logic              out_valid, out_ready;
    logic [ACC_W-1:0]  out_result;
    logic [10:0]       out_count;
    logic [15:0]       out_cycles;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dot_prod_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_a(in_a), .in_b(in_b),
        .r_enable(r_enable), .init_i_t_a(init_i_t_a), .init_acc_t_a(init_acc_t_a),
        .controlArr(controlArr),
        .controlArrWEnable_a(we_a), .controlArrWEnable_b(we_b),
        .controlArrAddr_a(addr_a), .controlArrAddr_b(addr_b),
        .controlArrWData_a(wd_a), .controlArrWData_b(wd_b),
        .w_enable(w_enable), .result(result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_count(out_count), .out_cycles(out_cycles)
    );

    // Engine model: reloads while r_enable is high, then walks init index..DEPTH-1
    logic signed [DATA_W-1:0] mem_a [DEPTH];
    logic signed [DATA_W-1:0] mem_b [DEPTH];
    int     eng_i;
    longint eng_acc;
    bit     eng_done;

    always @(posedge clk) begin
        if (we_a) mem_a[addr_a] <= wd_a;
        if (we_b) mem_b[addr_b] <= wd_b;
        if (r_enable) begin
            eng_i    <= int'(init_i_t_a);
            eng_acc  <= longint'(init_acc_t_a);
            eng_done <= 1'b0;
        end else if (!eng_done) begin
            eng_acc <= eng_acc + longint'(mem_a[eng_i]) * longint'(mem_b[eng_i]);
            if (eng_i == DEPTH - 1) eng_done <= 1'b1;
            else eng_i <= eng_i + 1;
        end
    end
    assign w_enable = eng_done;
    assign result   = eng_acc;

    typedef struct {
        int     n;
        int     a[3];
        int     b[3];
        longint exp_res;
        int     exp_init;
    } vec_t;

    vec_t vecs[4];
    int   va[DEPTH];
    int   vb[DEPTH];

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Push n pairs from va/vb; in_last on the final one only when use_last.
    task automatic send(input int n, input bit use_last);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            in_a     = DATA_W'(va[k]);
            in_b     = DATA_W'(vb[k]);
            in_last  = use_last && (k == n - 1);
            #4;
            chk("we_ab", {30'd0, we_a, we_b}, 3);
            chk("addr_a", longint'(addr_a), DEPTH - 1 - k);
            if (k < 4) begin
                chk("addr_b", longint'(addr_b), DEPTH - 1 - k);
                chk("wdata_a", longint'($signed(wd_a)), va[k]);
                chk("wdata_b", longint'($signed(wd_b)), vb[k]);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called just after the edge that enters KICK; returns just after HOLD is reached.
    task automatic finish_job(input longint exp_res, input int exp_cnt, input int exp_init);
        int g;
        chk("kick_ctrl", {controlArr, r_enable, in_ready, out_valid}, 4'b0100);
        chk("kick_init_i", longint'(init_i_t_a), exp_init);
        chk("kick_init_acc", longint'(init_acc_t_a), 0);
        in_valid = 1'b1;  // must be ignored outside LOAD
        #2;
        chk("kick_no_we", {we_a, we_b}, 0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("run_ctrl", {controlArr, r_enable, in_ready, out_valid}, 4'b0000);
        chk("run_init_i", longint'(init_i_t_a), exp_init);
        g = 0;
        while (!out_valid && g < 3000) begin
            @(posedge clk); #1;
            g++;
        end
        chk("hold_reached", longint'(out_valid), 1);
        chk("hold_r_enable", {controlArr, r_enable, in_ready}, 3'b010);
        chk("out_result", $signed(out_result), exp_res);
        chk("out_count", longint'(out_count), exp_cnt);
        chk("out_cycles", longint'(out_cycles), exp_cnt + 1);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("load_after_ack", {out_valid, in_ready, controlArr, r_enable}, 4'b0111);
        chk("cycles_cleared", longint'(out_cycles), 0);
    endtask

    initial begin
        longint held;
        vecs[0] = '{n: 3, a: '{1, 2, 3},  b: '{4, 5, 6}, exp_res: 32,  exp_init: 997};
        vecs[1] = '{n: 1, a: '{-5, 0, 0}, b: '{7, 0, 0}, exp_res: -35, exp_init: 999};
        vecs[2] = '{n: 1, a: '{1, 0, 0},  b: '{1, 0, 0}, exp_res: 1,   exp_init: 999};
        vecs[3] = '{n: 2, a: '{2, 2, 0},  b: '{3, 3, 0}, exp_res: 12,  exp_init: 998};

        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", longint'(in_ready), 0);
        chk("rst_ctrl", {r_enable, controlArr, out_valid, we_a, we_b}, 5'b11000);
        chk("rst_result", longint'(out_result), 0);
        chk("rst_count", longint'(out_count), 0);
        chk("rst_cycles", longint'(out_cycles), 0);
        chk("rst_init_i", longint'(init_i_t_a), DEPTH - 1);
        chk("rst_init_acc", longint'(init_acc_t_a), 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", longint'(in_ready), 1);
        @(posedge clk); #1;

        // Table: back-to-back jobs, each released immediately
        for (int v = 0; v < 4; v++) begin
            for (int k = 0; k < vecs[v].n; k++) begin
                va[k] = vecs[v].a[k];
                vb[k] = vecs[v].b[k];
            end
            send(vecs[v].n, 1'b1);
            finish_job(vecs[v].exp_res, vecs[v].n, vecs[v].exp_init);
            release_result();
        end

        // Full array without in_last: job ends on the 1000th pair
        for (int k = 0; k < DEPTH; k++) begin va[k] = 1; vb[k] = 1; end
        send(DEPTH, 1'b0);
        finish_job(1000, 1000, 0);

        // Stall in HOLD for 5 cycles; stray in_valid must be ignored
        held = $signed(out_result);
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("stall_valid", {out_valid, in_ready, we_a}, 3'b100);
            chk("stall_result", $signed(out_result), held);
            chk("stall_count", longint'(out_count), 1000);
        end
        in_valid = 1'b0;
        release_result();

        // Reset pulse in the middle of RUN
        va[0] = 4; va[1] = 4; va[2] = 4; vb[0] = 4; vb[1] = 4; vb[2] = 4;
        send(3, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_run", longint'(r_enable), 0);
        rst_n = 1'b0;
        #1;
        chk("midrun_rst", {out_valid, r_enable, controlArr, in_ready}, 4'b0110);
        chk("midrun_rst_cycles", longint'(out_cycles), 0);
        chk("midrun_rst_init", longint'(init_i_t_a), DEPTH - 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("after_rst_load", {in_ready, controlArr}, 2'b11);
        @(posedge clk); #1;
        va[0] = 2; vb[0] = 3;
        send(1, 1'b1);
        finish_job(6, 1, 999);
        release_result();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end
endmodule
